serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter NUMBITS, default 8, giving the operand/result width; legal values are 2..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: one clock; reset is synchronous and active-low (reset=0 sampled at a rising clk edge resets).
REQ-004 The block SHALL have port start, input, 1, a request to begin a subtraction, sampled only in IDLE.
REQ-005 The block SHALL have port A, input, NUMBITS, the minuend, captured when start is accepted.
REQ-006 The block SHALL have port B, input, NUMBITS, the subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port borrowin, input, 1, the initial borrow, captured when start is accepted.
REQ-008 The block SHALL have port result, output, NUMBITS, holding A-B-borrowin mod 2^NUMBITS.
REQ-009 The block SHALL have port borrowout, output, 1, asserted when A < B+borrowin (unsigned).
REQ-010 The block SHALL have port overflow, output, 1, flagging two's-complement signed overflow.
REQ-011 The block SHALL have port busy, output, 1, high while in RUN.
REQ-012 The block SHALL have port done, output, 1, a single-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE, encoded in registers.
REQ-014 In IDLE with start=1, the block SHALL latch A, B and borrowin into shift/borrow registers, clear the bit counter, and go to RUN.
REQ-015 In IDLE with start=0, the FSM SHALL stay in IDLE and all outputs SHALL hold.
REQ-016 In RUN, the block SHALL process one bit per cycle, LSB first: d = a^b^brw; brw_next = (~a&b) | (~(a^b)&brw).
REQ-017 In RUN, the d bit SHALL shift into the result register from the MSB side, and the counter SHALL increment.
REQ-018 After exactly NUMBITS RUN cycles, the FSM SHALL go to DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-020 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+NUMBITS+1.
REQ-021 result, borrowout and overflow SHALL update only on entry to DONE, and SHALL hold until the next completion or reset.
REQ-022 borrowout SHALL equal the final brw.
REQ-023 overflow SHALL equal (A[MSB]!=B[MSB]) && (result[MSB]!=A[MSB]), computed from the latched operands.
REQ-024 start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-025 A, B and borrowin changes after acceptance SHALL NOT affect the in-flight operation.
REQ-026 The boundary case 0 - 0 with borrowin=1 SHALL give result = all ones and borrowout = 1.
REQ-027 busy SHALL be high in every RUN cycle and low in IDLE and DONE.

Reset
REQ-028 With reset=0 at a rising edge, the FSM SHALL go to IDLE, and result, borrowout, overflow, busy and done SHALL all be 0.
REQ-029 reset=0 during RUN or DONE SHALL abort the operation; no done pulse SHALL follow, and outputs SHALL be as in REQ-028.
REQ-030 If reset=0 and start=1 occur together, reset SHALL win; start SHALL be accepted no earlier than the first edge with reset=1.

Verification (NUMBITS=8 unless stated; borrowin=0 unless stated)
REQ-031 The bench SHALL cover basic results: 0-0 -> result 0x00, borrowout 0, overflow 0; 0x80-0x01 -> result 0x7F, borrowout 0, overflow 1; 0x00-0x01 -> result 0xFF, borrowout 1, overflow 0.
REQ-032 The bench SHALL cover more values: 169-46 -> 123, borrowout 0; 13-146 -> 123, borrowout 1; 0-0 with borrowin=1 -> 0xFF, borrowout 1.
REQ-033 The bench SHALL check timing: start pulsed at edge k -> busy high for 8 cycles, done high exactly one cycle after edge k+9, done low otherwise.
REQ-034 The bench SHALL check start while busy: 10-3 accepted, then start with 200-1 mid-RUN -> only result 7 reported and one done pulse.
REQ-035 The bench SHALL check reset mid-RUN: reset=0 at cycle 4 of RUN -> all outputs 0 next cycle, no done; a new 5-5 then gives 0.
REQ-036 The bench SHALL check wide instances: 16-bit 0x0000-0x0001 -> 0xFFFF, borrowout 1; 32-bit 0x00000000-0x00000001 -> 0xFFFFFFFF, borrowout 1, done after 33 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - borrowin one bit per clock, LSB first,
// and reports result, final borrow and signed overflow with a one-cycle done pulse.
module serial_subtractor #(
    parameter int NUMBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic               borrowin,
    output logic [NUMBITS-1:0] result,
    output logic               borrowout,
    output logic               overflow,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = $clog2(NUMBITS);
    localparam logic [CW-1:0] LAST = CW'(NUMBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [NUMBITS-1:0] r_a;
    logic [NUMBITS-1:0] r_b;
    logic [NUMBITS-1:0] r_diff;
    logic               r_brw;
    logic [CW-1:0]      r_cnt;
    logic [NUMBITS-1:0] r_result;
    logic               r_borrowout;
    logic               r_overflow;
    logic               r_done;

    logic               w_last;
    logic               w_d;
    logic               w_brw_next;

    assign w_last     = (r_state == RUN) && (r_cnt == LAST);
    assign w_d        = r_a[0] ^ r_b[0] ^ r_brw;
    assign w_brw_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_brw       <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_borrowout <= 1'b0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // done is registered from DONE so it lands one edge after the state entry
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_brw <= borrowin;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_brw  <= w_brw_next;
                    r_diff <= {w_d, r_diff[NUMBITS-1:1]};
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        // on the last step r_a[0]/r_b[0] hold the operand MSBs and w_d is the result MSB
                        r_result    <= {w_d, r_diff[NUMBITS-1:1]};
                        r_borrowout <= w_brw_next;
                        r_overflow  <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = r_result;
    assign borrowout = r_borrowout;
    assign overflow  = r_overflow;
    assign busy      = (r_state == RUN);
    assign done      = r_done;

endmodule
